// File: rtl/light_game_pkg.sv
// Shared types and constants for the catch-the-light round controller.
`timescale 1ns/1ps
package light_game_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    PLAY,
    OVER
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic lfsr_fb(input logic [15:0] q);
    return ^(q & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used to pick the next lit target.
`timescale 1ns/1ps
module lfsr16
  import light_game_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= LFSR_SEED;
    end else begin
      q <= {q[14:0], lfsr_fb(q)};
    end
  end

endmodule

// File: rtl/light_game_ctrl.sv
// Round controller for catch-the-light: arm timer, light target, score hits.
// Define MISS_PENALTY_EN to make misses cost one point (floor at zero).
`timescale 1ns/1ps
module light_game_ctrl
  import light_game_pkg::*;
#(
  parameter int NUM_LIGHTS = 8,
  parameter int SCORE_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [NUM_LIGHTS-1:0] btn,
  input  logic                  time_up,
  output logic                  timer_rst,
  output logic [NUM_LIGHTS-1:0] led,
  output logic [SCORE_W-1:0]    score,
  output logic [SCORE_W-1:0]    high_score,
  output logic                  game_over,
  output logic                  busy
);

  localparam int IW = $clog2(NUM_LIGHTS);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

`ifdef MISS_PENALTY_EN
  localparam bit MISS_PENALTY = 1'b1;
`else
  localparam bit MISS_PENALTY = 1'b0;
`endif

  function automatic logic [NUM_LIGHTS-1:0] onehot(
    input logic [IW-1:0] idx
  );
    return NUM_LIGHTS'(1) << idx;
  endfunction

  state_t                state;
  logic [15:0]           lfsr_q;
  logic [IW-1:0]         target;
  logic [IW-1:0]         cand;
  logic [IW-1:0]         next_target;
  logic [NUM_LIGHTS-1:0] btn_q;
  logic [NUM_LIGHTS-1:0] rise;
  logic                  hit;
  logic                  miss;
  logic                  unused_lfsr;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr_q)
  );

  // Bumping a repeated candidate guarantees the light always moves.
  assign cand        = lfsr_q[IW-1:0];
  assign next_target = (cand == target) ? cand + IW'(1) : cand;
  assign unused_lfsr = ^lfsr_q[15:IW];

  assign rise = btn & ~btn_q;
  assign hit  = (rise == onehot(target));
  assign miss = (rise != '0) && !hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      btn_q      <= '0;
      target     <= '0;
      timer_rst  <= 1'b0;
      led        <= '0;
      score      <= '0;
      high_score <= '0;
      game_over  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      btn_q     <= btn;
      timer_rst <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= ARM;
            timer_rst <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ARM: begin
          state  <= PLAY;
          score  <= '0;
          target <= next_target;
          led    <= onehot(next_target);
        end
        PLAY: begin
          if (time_up) begin
            state     <= OVER;
            led       <= '0;
            game_over <= 1'b1;
            busy      <= 1'b0;
          end else if (hit) begin
            if (score != SCORE_MAX) begin
              score <= score + SCORE_W'(1);
            end
            target <= next_target;
            led    <= onehot(next_target);
          end else if (miss && MISS_PENALTY && score != '0) begin
            score <= score - SCORE_W'(1);
          end
        end
        OVER: begin
          if (score > high_score) begin
            high_score <= score;
          end
          if (start) begin
            state     <= ARM;
            timer_rst <= 1'b1;
            busy      <= 1'b1;
            game_over <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_light_game_ctrl.sv
// Scoreboard bench for light_game_ctrl (8 lights) plus a 2-bit-score twin.
`timescale 1ns/1ps
module tb_light_game_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] btn;
  logic       time_up;

  logic       timer_rst, game_over, busy;
  logic [7:0] led, score, high_score;
  logic       timer_rst2, game_over2, busy2;
  logic [7:0] led2;
  logic [1:0] score2, high_score2;

  light_game_ctrl u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .btn        (btn),
    .time_up    (time_up),
    .timer_rst  (timer_rst),
    .led        (led),
    .score      (score),
    .high_score (high_score),
    .game_over  (game_over),
    .busy       (busy)
  );

  light_game_ctrl #(.NUM_LIGHTS(8), .SCORE_W(2)) u_dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .btn        (btn),
    .time_up    (time_up),
    .timer_rst  (timer_rst2),
    .led        (led2),
    .score      (score2),
    .high_score (high_score2),
    .game_over  (game_over2),
    .busy       (busy2)
  );

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    string      tag;
    int         due;
    logic [7:0] led;
    logic [7:0] score;
    logic [7:0] hs;
    logic [1:0] s2;
    logic       go;
    logic       busy;
    logic       trst;
  } vec_t;

  vec_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  logic [2:0] tgt, old, w;
  int         sc, hs;

  function automatic logic [15:0] lfsr_at(int n);
    logic [15:0] q;
    q = 16'hACE1;
    for (int i = 0; i < n; i++)
      q = {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    return q;
  endfunction

  function automatic logic [2:0] pick(logic [2:0] cur, int n);
    logic [15:0] q;
    logic [2:0]  c;
    q = lfsr_at(n);
    c = q[2:0];
    return (c == cur) ? c + 3'd1 : c;
  endfunction

  function automatic logic [7:0] lit(logic [2:0] i);
    logic [7:0] one;
    one = 8'd1;
    return one << i;
  endfunction

  task automatic push_v(string tag, logic [7:0] l, logic go,
                        logic bz, logic tr, int due);
    vec_t v;
    v.tag   = tag;
    v.due   = due;
    v.led   = l;
    v.score = 8'(sc);
    v.hs    = 8'(hs);
    v.s2    = (sc > 3) ? 2'd3 : 2'(sc);
    v.go    = go;
    v.busy  = bz;
    v.trst  = tr;
    sb.push_back(v);
  endtask

  task automatic vstep(string tag, logic s, logic [7:0] b, logic t,
                       logic [7:0] l, logic go, logic bz, logic tr);
    start   = s;
    btn     = b;
    time_up = t;
    push_v(tag, l, go, bz, tr, cyc + 1);
    @(negedge clk);
  endtask

  // Monitor: compares every expectation that falls due after each edge.
  initial begin
    vec_t v;
    forever begin
      @(posedge clk);
      #1;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        v = sb.pop_front();
        n_vec++;
        if (v.due != cyc || led !== v.led || led2 !== v.led ||
            score !== v.score || score2 !== v.s2 ||
            high_score !== v.hs || game_over !== v.go ||
            busy !== v.busy || timer_rst !== v.trst) begin
          n_bad++;
          $display({"FAIL %s cyc=%0d: got led=%h led2=%h score=%0d ",
                    "s2=%0d hs=%0d go=%b busy=%b trst=%b; want led=%h ",
                    "score=%0d s2=%0d hs=%0d go=%b busy=%b trst=%b"},
                   v.tag, cyc, led, led2, score, score2, high_score,
                   game_over, busy, timer_rst, v.led, v.score, v.s2,
                   v.hs, v.go, v.busy, v.trst);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; btn = '0; time_up = 1'b0;
    tgt = '0; sc = 0; hs = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    vstep("reset", 0, 8'h00, 0, 8'h00, 0, 0, 0);
    vstep("start", 1, 8'h00, 0, 8'h00, 0, 1, 1);
    tgt = pick(tgt, cyc); sc = 0;
    vstep("arm", 0, 8'h00, 0, lit(tgt), 0, 1, 0);
    vstep("play_idle", 0, 8'h00, 0, lit(tgt), 0, 1, 0);

    for (int k = 0; k < 3; k++) begin
      old = tgt; tgt = pick(tgt, cyc); sc++;
      vstep("hit", 0, lit(old), 0, lit(tgt), 0, 1, 0);
      vstep("release", 0, 8'h00, 0, lit(tgt), 0, 1, 0);
    end

    old = tgt; tgt = pick(tgt, cyc); sc++;
    vstep("hold_first", 0, lit(old), 0, lit(tgt), 0, 1, 0);
    repeat (9) vstep("hold", 0, lit(old), 0, lit(tgt), 0, 1, 0);
    vstep("hold_release", 0, 8'h00, 0, lit(tgt), 0, 1, 0);

    old = tgt; tgt = pick(tgt, cyc); sc++;
    vstep("hit5", 0, lit(old), 0, lit(tgt), 0, 1, 0);
    vstep("release5", 0, 8'h00, 0, lit(tgt), 0, 1, 0);

    vstep("timeup_hit", 0, lit(tgt), 1, 8'h00, 1, 0, 0);
    hs = 5;
    vstep("hs_update", 0, 8'h00, 0, 8'h00, 1, 0, 0);

    vstep("restart", 1, 8'h00, 0, 8'h00, 0, 1, 1);
    tgt = pick(tgt, cyc); sc = 0;
    vstep("arm2", 0, 8'h00, 0, lit(tgt), 0, 1, 0);
    old = tgt; tgt = pick(tgt, cyc); sc = 1;
    vstep("hit_r2", 0, lit(old), 0, lit(tgt), 0, 1, 0);
    vstep("release_r2", 0, 8'h00, 0, lit(tgt), 0, 1, 0);

    w = tgt + 3'd1;
`ifdef MISS_PENALTY_EN
    if (sc > 0) sc--;
`endif
    vstep("miss_wrong", 0, lit(w), 0, lit(tgt), 0, 1, 0);
    vstep("release_w", 0, 8'h00, 0, lit(tgt), 0, 1, 0);
`ifdef MISS_PENALTY_EN
    if (sc > 0) sc--;
`endif
    vstep("miss_multi", 0, lit(tgt) | lit(w), 0, lit(tgt), 0, 1, 0);
    vstep("release_m", 0, 8'h00, 0, lit(tgt), 0, 1, 0);

    vstep("timeup_r2", 0, lit(tgt), 1, 8'h00, 1, 0, 0);
    vstep("hs_keep", 0, 8'h00, 0, 8'h00, 1, 0, 0);

    vstep("restart3", 1, 8'h00, 0, 8'h00, 0, 1, 1);
    tgt = pick(tgt, cyc); sc = 0;
    vstep("arm3", 0, 8'h00, 0, lit(tgt), 0, 1, 0);
    old = tgt; tgt = pick(tgt, cyc); sc = 1;
    vstep("hit_r3", 0, lit(old), 0, lit(tgt), 0, 1, 0);

    rst_n = 1'b0; btn = '0;
    #1;
    sc = 0; hs = 0; tgt = '0;
    push_v("mid_reset", 8'h00, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    vstep("post_reset", 0, 8'h00, 0, 8'h00, 0, 0, 0);
    vstep("start4", 1, 8'h00, 0, 8'h00, 0, 1, 1);
    tgt = pick(tgt, cyc);
    vstep("arm4", 0, 8'h00, 0, lit(tgt), 0, 1, 0);

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      $display("FAIL drain: got %0d pending, want 0", sb.size());
      n_bad += sb.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/light_game_ctrl.md
# light_game_ctrl

Round controller for the catch-the-light game, the consumer of the countdown timer. Starts a round by reloading the timer, lights one pseudo-random LED, scores correct button presses, re-targets on each hit, and ends the round when the timer's `time_up` arrives. Sits between the debounced button/start inputs, the countdown timer, and the LED/score display logic.

## Interface
- `NUM_LIGHTS`, 8, number of lights/buttons; power of two, 2..16
- `SCORE_W`, 8, score and high-score width
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  level or pulse, synchronized; begins a round from IDLE/OVER
- `btn`  in  NUM_LIGHTS  synchronized, debounced button levels, bit i = light i
- `time_up`  in  1  from countdown timer; high means round time expired
- `timer_rst`  out  1  active-high synchronous reload to the countdown timer
- `led`  out  NUM_LIGHTS  one-hot lit light; all-zero when no round active
- `score`  out  SCORE_W  hits in current/last round
- `high_score`  out  SCORE_W  best score since reset
- `game_over`  out  1  high in OVER
- `busy`  out  1  high in ARM or PLAY

## Operation
- States: IDLE, ARM, PLAY, OVER.
- IDLE: `start`=1 -> ARM.
- ARM (exactly 1 cycle): `timer_rst`=1, `score`<=0, target index loaded from LFSR rule; -> PLAY. `time_up` ignored.
- PLAY: `led` = one-hot(target). Rising edges of `btn` detected against a registered previous `btn` (prev register reset to 0).
  - Hit: rising-edge vector equals exactly one-hot(target) -> `score`+1, saturating at 2^SCORE_W-1; new target chosen.
  - Miss: any other non-zero rising-edge vector (wrong button, or several at once even if one is the target) -> see Configuration; target unchanged.
  - `time_up`=1 -> OVER; takes priority over a hit/miss in the same cycle (press not counted).
  - `start` ignored.
- OVER: `led`=0, `game_over`=1, `high_score` <= max(high_score, score) on entry cycle. `start`=1 -> ARM.
- Target selection: 16-bit Fibonacci LFSR, seed 16'hACE1, taps 16,14,13,11, advances every cycle from reset. Candidate = lfsr[log2(NUM_LIGHTS)-1:0]; if candidate equals current target, use (candidate+1) mod NUM_LIGHTS. New target always differs from previous (also on ARM, versus last round's target; target register resets to 0).
- `high_score` cleared only by `rst_n`.

## Timing
- Reset (async assert, sync-release assumed upstream): state IDLE, `led`=0, `score`=0, `high_score`=0, `game_over`=0, `busy`=0, `timer_rst`=0, lfsr=16'hACE1, target=0.
- All outputs registered or decoded from registered state only; no combinational path from inputs to outputs.
- `start` sampled at edge N in IDLE -> ARM during cycle N+1 (`timer_rst`=1) -> PLAY from N+2; timer clears `time_up` at the same edge, so PLAY never sees a stale `time_up`.
- Button rising edge sampled at edge N -> `score` and `led` updated at edge N+1 output (1-cycle latency).
- `time_up` sampled in PLAY at edge N -> `game_over`=1, `led`=0 from edge N+1; `high_score` valid from edge N+2.
- Held button: counts once; must be released and re-pressed.
- `rst_n` mid-round: immediate return to reset values; `high_score` lost.

## Configuration
- `MISS_PENALTY_EN` defined: a miss decrements `score` by 1, saturating at 0.
- Undefined: misses ignored; score changes only on hits.

## Structure
- Package `light_game_pkg`: state enum (IDLE, ARM, PLAY, OVER), LFSR seed 16'hACE1 and tap constants.
- Sub-module `lfsr16`: free-running 16-bit LFSR, `clk`/`rst_n`, output `q[15:0]`.

## Test plan
- Reset with `btn`=0 -> all outputs 0, state IDLE; `led`=8'h00.
- `start` pulse -> `timer_rst` high exactly one cycle, `busy`=1, `led` one-hot non-zero, `score`=0.
- Press lit button 3 times (release between) -> `score`=3, each new `led` differs from previous; holding a button 10 cycles counts once.
- Press wrong button, then two buttons including lit one simultaneously -> with `MISS_PENALTY_EN` after one hit `score` 1->0->0; without it `score` stays 1.
- Lit-button edge in same cycle as `time_up` -> `score` unchanged, `game_over`=1, `led`=0; `high_score`=score; second round with lower score keeps `high_score`.
- SCORE_W=2, 5 hits -> `score` saturates at 3; `rst_n` low mid-PLAY -> all outputs 0 immediately.
